// File: rtl/dm_to_dmi_resp.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dm_to_dmi_resp: DMI response path from the DM back to the JTAG DTM.     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module dm_to_dmi_resp #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_rd_i,
  input  logic        dmi_wr_i,
  input  logic [31:0] dm_do_i,
  input  logic        ack_tgl_i,
  input  logic        err_clr_i,
  output logic [31:0] resp_data_o,
  output logic [1:0]  resp_op_o,
  output logic        resp_tgl_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam logic [1:0] C_OP_OK   = 2'd0;
  localparam logic [1:0] C_OP_FAIL = 2'd2;
  localparam logic [1:0] C_OP_BUSY = 2'd3;
  localparam logic [3:0] C_LAT_INIT = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  op_q, op_d;
  logic        tgl_q, tgl_d;
  logic        ack_q1, ack_q2;
  logic        w_req;
  logic        w_set_busy;
  logic        w_set_fail;

  // Two-flop synchronizer for the TCK-domain acknowledge toggle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q1 <= 1'b0;
      ack_q2 <= 1'b0;
    end else begin
      ack_q1 <= ack_tgl_i;
      ack_q2 <= ack_q1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      data_q    <= 32'd0;
      op_q      <= C_OP_OK;
      tgl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      data_q    <= data_d;
      op_q      <= op_d;
      tgl_q     <= tgl_d;
    end
  end

  assign w_req      = dmi_rd_i | dmi_wr_i;
  assign w_set_busy = (state_q != IDLE) && w_req;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    data_d     = data_q;
    tgl_d      = tgl_q;
    w_set_fail = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmi_rd_i && dmi_wr_i) begin
          // Illegal combination still gets a response so the DTM never hangs.
          w_set_fail = 1'b1;
          data_d     = 32'd0;
          tgl_d      = ~tgl_q;
          state_d    = PEND;
        end else if (dmi_wr_i) begin
          data_d  = 32'd0;
          tgl_d   = ~tgl_q;
          state_d = PEND;
        end else if (dmi_rd_i) begin
          if (RD_LAT == 0) begin
            data_d  = dm_do_i;
            tgl_d   = ~tgl_q;
            state_d = PEND;
          end else begin
            lat_cnt_d = C_LAT_INIT;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          data_d  = dm_do_i;
          tgl_d   = ~tgl_q;
          state_d = PEND;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      PEND: begin
        if (ack_q2 == tgl_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky status: busy dominates failed, and any set beats a same-cycle clear.
  always_comb begin
    op_d = op_q;
    if (w_set_busy) begin
      op_d = C_OP_BUSY;
    end else if (w_set_fail) begin
      op_d = (op_q == C_OP_BUSY) ? C_OP_BUSY : C_OP_FAIL;
    end else if (err_clr_i) begin
      op_d = C_OP_OK;
    end
  end

  assign resp_data_o = data_q;
  assign resp_op_o   = op_q;
  assign resp_tgl_o  = tgl_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_to_dmi_resp.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dm_to_dmi_resp: directed and random checks of three RD_LAT builds.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_dm_to_dmi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd  [3];
  logic        wr  [3];
  logic        clr [3];
  logic        ack [3];
  logic [31:0] dm_do;
  logic [31:0] data_o [3];
  logic [1:0]  op_o   [3];
  logic        tgl_o  [3];
  logic        busy_o [3];

  int checks   = 0;
  int failures = 0;
  int lat [3]  = '{1, 0, 15};

  // Reference model: a response becomes due at the request edge plus latency.
  bit          m_busy [3];
  bit          m_pub  [3];
  bit          m_tgl  [3];
  int          m_due  [3];
  logic [31:0] m_data [3];
  logic [1:0]  m_op   [3];
  bit          ack_hist [3][2];
  int          n = 0;

  always #5 clk = ~clk;

  dm_to_dmi_resp #(.RD_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_rd_i(rd[0]), .dmi_wr_i(wr[0]),
    .dm_do_i(dm_do), .ack_tgl_i(ack[0]), .err_clr_i(clr[0]),
    .resp_data_o(data_o[0]), .resp_op_o(op_o[0]), .resp_tgl_o(tgl_o[0]),
    .busy_o(busy_o[0]));

  dm_to_dmi_resp #(.RD_LAT(0)) u_lat0 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_rd_i(rd[1]), .dmi_wr_i(wr[1]),
    .dm_do_i(dm_do), .ack_tgl_i(ack[1]), .err_clr_i(clr[1]),
    .resp_data_o(data_o[1]), .resp_op_o(op_o[1]), .resp_tgl_o(tgl_o[1]),
    .busy_o(busy_o[1]));

  dm_to_dmi_resp #(.RD_LAT(15)) u_lat15 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_rd_i(rd[2]), .dmi_wr_i(wr[2]),
    .dm_do_i(dm_do), .ack_tgl_i(ack[2]), .err_clr_i(clr[2]),
    .resp_data_o(data_o[2]), .resp_op_o(op_o[2]), .resp_tgl_o(tgl_o[2]),
    .busy_o(busy_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0; m_pub[i] = 1'b0; m_tgl[i] = 1'b0; m_due[i] = 0;
      m_data[i] = 32'd0; m_op[i] = 2'd0;
      ack_hist[i][0] = 1'b0; ack_hist[i][1] = 1'b0;
    end
  endtask

  task automatic publish(input int i, input logic [31:0] v);
    m_data[i] = v;
    m_tgl[i]  = ~m_tgl[i];
    m_pub[i]  = 1'b1;
  endtask

  task automatic model_edge();
    bit set_busy, set_fail;
    for (int i = 0; i < 3; i++) begin
      set_busy = 1'b0;
      set_fail = 1'b0;
      if (!m_busy[i]) begin
        if (rd[i] || wr[i]) begin
          m_busy[i] = 1'b1;
          if (rd[i] && wr[i]) begin
            set_fail = 1'b1;
            publish(i, 32'd0);
          end else if (wr[i]) begin
            publish(i, 32'd0);
          end else if (lat[i] == 0) begin
            publish(i, dm_do);
          end else begin
            m_due[i] = n + lat[i];
          end
        end
      end else begin
        set_busy = rd[i] || wr[i];
        if (!m_pub[i]) begin
          if (n == m_due[i]) publish(i, dm_do);
        end else if (ack_hist[i][1] == m_tgl[i]) begin
          m_busy[i] = 1'b0;
          m_pub[i]  = 1'b0;
        end
      end
      if (set_busy)      m_op[i] = 2'd3;
      else if (set_fail) m_op[i] = (m_op[i] == 2'd3) ? 2'd3 : 2'd2;
      else if (clr[i])   m_op[i] = 2'd0;
      // Acknowledge becomes visible to the FSM two edges after it is sampled.
      ack_hist[i][1] = ack_hist[i][0];
      ack_hist[i][0] = ack[i];
    end
    n++;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("data%0d", i), data_o[i], m_data[i]);
      check($sformatf("op%0d", i), {30'd0, op_o[i]}, {30'd0, m_op[i]});
      check($sformatf("tgl%0d", i), {31'd0, tgl_o[i]}, {31'd0, m_tgl[i]});
      check($sformatf("busy%0d", i), {31'd0, busy_o[i]}, {31'd0, m_busy[i]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; clr[i] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_data%0d", tag, i), data_o[i], 32'd0);
      check($sformatf("%s_op%0d", tag, i), {30'd0, op_o[i]}, 32'd0);
      check($sformatf("%s_tgl%0d", tag, i), {31'd0, tgl_o[i]}, 32'd0);
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy_o[i]}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dm_do = 32'd0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; clr[i] = 1'b0; ack[i] = 1'b0;
    end
    model_reset();
    #1;
    check_zero("rst_async");
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;

    // Read with latency 1.
    rd[0] = 1'b1;
    step();
    check("rd1_busy", {31'd0, busy_o[0]}, 32'd1);
    dm_do = 32'hDEADBEEF;
    step();
    dm_do = 32'd0;
    check("rd1_data", data_o[0], 32'hDEADBEEF);
    check("rd1_tgl", {31'd0, tgl_o[0]}, 32'd1);

    // Acknowledge returns after two synchronizer stages.
    ack[0] = 1'b1;
    step();
    step();
    check("ack_busy_e1", {31'd0, busy_o[0]}, 32'd1);
    step();
    check("ack_idle", {31'd0, busy_o[0]}, 32'd0);

    wr[0] = 1'b1;
    step();
    check("wr_data", data_o[0], 32'd0);
    check("wr_tgl", {31'd0, tgl_o[0]}, 32'd0);
    check("wr_op", {30'd0, op_o[0]}, 32'd0);
    ack[0] = 1'b0;
    repeat (3) step();

    // Request while pending is dropped and flagged busy.
    rd[0] = 1'b1;
    step();
    dm_do = 32'h00001234;
    step();
    dm_do = 32'd0;
    rd[0] = 1'b1;
    step();
    check("busy_op", {30'd0, op_o[0]}, 32'd3);
    check("busy_tgl", {31'd0, tgl_o[0]}, 32'd1);
    check("busy_data", data_o[0], 32'h00001234);
    ack[0] = 1'b1;
    repeat (3) step();
    check("busy_idle", {31'd0, busy_o[0]}, 32'd0);
    check("busy_sticky", {30'd0, op_o[0]}, 32'd3);
    clr[0] = 1'b1;
    step();
    check("clr_op", {30'd0, op_o[0]}, 32'd0);
    rd[0] = 1'b1;
    step();
    rd[0] = 1'b1; clr[0] = 1'b1; dm_do = 32'h0BADF00D;
    step();
    dm_do = 32'd0;
    check("set_beats_clr", {30'd0, op_o[0]}, 32'd3);
    check("wait_data", data_o[0], 32'h0BADF00D);
    ack[0] = 1'b0;
    repeat (3) step();
    clr[0] = 1'b1;
    step();

    // Latency 0 build.
    rd[1] = 1'b1; dm_do = 32'hA5A5A5A5;
    step();
    dm_do = 32'd0;
    check("lat0_data", data_o[1], 32'hA5A5A5A5);
    check("lat0_tgl", {31'd0, tgl_o[1]}, 32'd1);
    ack[1] = 1'b1;
    repeat (3) step();

    // Latency 15 build.
    rd[2] = 1'b1;
    step();
    repeat (14) step();
    check("lat15_early_tgl", {31'd0, tgl_o[2]}, 32'd0);
    dm_do = 32'hCAFEF00D;
    step();
    dm_do = 32'd0;
    check("lat15_data", data_o[2], 32'hCAFEF00D);
    check("lat15_tgl", {31'd0, tgl_o[2]}, 32'd1);
    ack[2] = 1'b1;
    repeat (3) step();

    // Simultaneous read and write.
    rd[0] = 1'b1; wr[0] = 1'b1; dm_do = 32'h55555555;
    step();
    dm_do = 32'd0;
    check("rdwr_op", {30'd0, op_o[0]}, 32'd2);
    check("rdwr_data", data_o[0], 32'd0);
    check("rdwr_tgl", {31'd0, tgl_o[0]}, 32'd1);
    rd[0] = 1'b1;
    step();
    check("rdwr_then_busy", {30'd0, op_o[0]}, 32'd3);
    ack[0] = 1'b1;
    repeat (3) step();
    clr[0] = 1'b1;
    step();

    // Asynchronous reset with lat1 in PEND and lat15 in WAIT.
    rd[0] = 1'b1; rd[2] = 1'b1;
    step();
    dm_do = 32'h00000011;
    step();
    dm_do = 32'd0;
    check("pre_rst_busy0", {31'd0, busy_o[0]}, 32'd1);
    check("pre_rst_busy2", {31'd0, busy_o[2]}, 32'd1);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) ack[i] = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd[0] = 1'b1;
    step();
    dm_do = 32'h00000077;
    step();
    dm_do = 32'd0;
    check("post_rst_data", data_o[0], 32'h00000077);
    check("post_rst_tgl", {31'd0, tgl_o[0]}, 32'd1);
    ack[0] = 1'b1;
    repeat (3) step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rd[i]  = ($urandom_range(0, 7) == 0);
        wr[i]  = ($urandom_range(0, 9) == 0);
        clr[i] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 2) == 0) ack[i] = m_tgl[i];
      end
      dm_do = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_to_dmi_resp.md
Name: dm_to_dmi_resp

Overview:
- Return path of the DMI, sitting in the core clock domain between the DM (`dm_inst`) and the JTAG-side DTM; the counterpart of the request synchronizer.
- Takes the synchronized single-cycle `dmi_rd`/`dmi_wr` pulses already delivered to the DM. Captures DM read data after a fixed DM latency.
- Publishes data plus a 2-bit op status in a stable holding register, and signals a new response by flipping `resp_tgl_o`.
- Waits for the DTM to echo the toggle back (`ack_tgl_i`, asynchronous, synchronized internally) before accepting the next request. Requests arriving while busy are dropped and flagged with a sticky busy status.

Parameters:
- `RD_LAT`, 1: core clock cycles from the `dmi_rd_i` pulse to valid `dm_do_i`; legal range 0..15.

Ports:
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `dmi_rd_i`  in  1  synchronized DMI read pulse (one cycle wide)
- `dmi_wr_i`  in  1  synchronized DMI write pulse (one cycle wide)
- `dm_do_i`  in  32  DM read data; valid `RD_LAT` cycles after `dmi_rd_i`
- `ack_tgl_i`  in  1  acknowledge toggle from the TCK domain (asynchronous)
- `err_clr_i`  in  1  clears the sticky op status (dmireset)
- `resp_data_o`  out  32  held response data
- `resp_op_o`  out  2  sticky status: 0 = ok, 2 = failed, 3 = busy
- `resp_tgl_o`  out  1  toggles once per published response
- `busy_o`  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset: asynchronous on `rst_ni` low, effective immediately, mid-transaction included.
  - FSM goes to IDLE; `lat_cnt` = 0.
  - `resp_data_o` = 0, `resp_op_o` = 0, `resp_tgl_o` = 0, `busy_o` = 0.
  - Both ack synchronizer flops = 0.
- Ack synchronizer: two flops, `ack_q1` <= `ack_tgl_i`, then `ack_q2` <= `ack_q1`. Only `ack_q2` is used. No other use of `ack_tgl_i`.
- States: IDLE, WAIT, PEND.
- IDLE, `dmi_rd_i` only:
  - `RD_LAT` = 0: capture `dm_do_i` this edge (pulse cycle T), flip `resp_tgl_o`, go to PEND. Output visible at T+1.
  - `RD_LAT` > 0: load `lat_cnt` = `RD_LAT` - 1, go to WAIT.
- IDLE, `dmi_wr_i` only: `resp_data_o` <= 0, flip `resp_tgl_o`, go to PEND. Visible at T+1.
- IDLE, `dmi_rd_i` and `dmi_wr_i` in the same cycle: illegal.
  - Set sticky op = 2 (unless it is already 3).
  - `resp_data_o` <= 0, flip `resp_tgl_o`, go to PEND, so the DTM never hangs.
- WAIT:
  - If `lat_cnt` = 0: capture `dm_do_i`, flip `resp_tgl_o`, go to PEND.
  - Else decrement `lat_cnt`.
  - Read data is therefore sampled exactly at T+`RD_LAT` and visible at T+`RD_LAT`+1.
- PEND: when `ack_q2` == `resp_tgl_o`, go to IDLE on that edge.
  - A new request is accepted in the cycle after IDLE is reached.
- `resp_data_o` and `resp_tgl_o` change only on the publish edge. Data is stable whenever the toggle differs from `ack_q2`.
- `busy_o` = (state != IDLE); registered-state decode, no input path.
- Request (`dmi_rd_i` or `dmi_wr_i`) while in WAIT or PEND:
  - The request is dropped: no data capture, no toggle.
  - Sticky op <= 3; busy overrides a failed status of 2.
  - The in-flight transaction completes unaffected.
- Sticky op:
  - Drives `resp_op_o` directly.
  - Cleared to 0 by `err_clr_i`.
  - If a set and `err_clr_i` occur in the same cycle, the set wins.
  - Not cleared by publishing a response.
- Ack toggle seen in IDLE or WAIT (spurious, `ack_q2` already equal): ignored, no state change.
- No arithmetic beyond the 4-bit down-counter; the counter never wraps (only decremented while nonzero in WAIT).

Test Plan:
- Reset values, then read with `RD_LAT`=1: hold `rst_ni`=0 and check all outputs are 0. Then pulse `dmi_rd_i` at cycle T with `dm_do_i`=32'hDEADBEEF at T+1 -> `resp_data_o`=32'hDEADBEEF and `resp_tgl_o`=1 at T+2; `busy_o`=1 from T+1.
- Ack return: set `ack_tgl_i`=1 before edge E -> IDLE and `busy_o`=0 after edge E+2. Then pulse `dmi_wr_i` -> `resp_data_o`=0, `resp_tgl_o`=0 one cycle later, `resp_op_o`=0.
- Busy case: pulse `dmi_rd_i` while in PEND with `ack_tgl_i` held -> no toggle, `resp_op_o`=3. Ack the first response -> IDLE; `resp_op_o` stays 3 until `err_clr_i`, then 0. `err_clr_i` coinciding with a new busy event -> `resp_op_o`=3.
- `RD_LAT`=0 and `RD_LAT`=15 builds: `dm_do_i` is valid only at T+`RD_LAT` (other cycles 32'h0) -> correct word captured and visible at T+`RD_LAT`+1 in both builds.
- Simultaneous `dmi_rd_i`=`dmi_wr_i`=1 in IDLE -> `resp_op_o`=2, `resp_data_o`=0, toggle flips. A later busy event -> `resp_op_o`=3.
- Reset mid-WAIT and mid-PEND (assert `rst_ni` between clock edges) -> outputs 0 immediately without waiting for a clock edge. The first request after release is accepted normally.
